// File: rtl/source2.sv
// source2: two-phase traffic generator; one item per req transition,
// programmable gap, transfer count, stop and protocol error flags.
// Ports: clk, reset (async, active low), en (gap counting enable),
//   req/ack (two-phase handshake), data (item value),
//   sent (completed transfers), done (COUNT reached),
//   err ([0] protocol violation, [1] ack timeout; both sticky).
// Optional: define SOURCE2_TIMEOUT_EN to enable the ack timeout.
module source2 #(
  parameter int ID      = 0,
  parameter int SIZE    = 8,
  parameter int PERIOD  = 4,
  parameter int COUNT   = 0,
  parameter int START   = 0,
  parameter int STEP    = 1,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  output logic            req,
  input  logic            ack,
  output logic [SIZE-1:0] data,
  output logic [15:0]     sent,
  output logic            done,
  output logic [1:0]      err
);

  typedef enum logic [1:0] {
    S_GAP,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [SIZE-1:0] START_V = SIZE'(START);
  localparam logic [SIZE-1:0] STEP_V  = SIZE'(STEP);
  localparam logic [15:0]     LAST    = 16'(PERIOD - 1);
  localparam logic [15:0]     CNT_V   = 16'(COUNT);

  if (PERIOD < 1 || TIMEOUT < 1 || ID < 0) begin : g_bad_cfg
    $error("source2: illegal parameter value");
  end

  state_t          state, state_n;
  logic            req_n;
  logic [SIZE-1:0] data_n;
  logic [SIZE-1:0] item;
  logic [15:0]     sent_n;
  logic [15:0]     cnt, cnt_n;
  logic            pend;
  logic            viol, viol_r;
  logic            tmo;

  assign pend = req ^ ack;
  // Item k is derived from the transfer count, so it tracks sent's wrap.
  assign item = START_V + SIZE'(sent) * STEP_V;

  always_comb begin
    state_n = state;
    req_n   = req;
    data_n  = data;
    sent_n  = sent;
    cnt_n   = cnt;
    viol    = 1'b0;
    unique case (state)
      S_GAP: begin
        viol = pend;
        if (en) begin
          if (cnt == LAST) begin
            req_n   = ~req;
            data_n  = item;
            state_n = S_WAIT;
          end else begin
            cnt_n = cnt + 16'd1;
          end
        end
      end
      S_WAIT: begin
        if (!pend) begin
          sent_n = sent + 16'd1;
          cnt_n  = '0;
          if (COUNT != 0 && sent_n == CNT_V)
            state_n = S_DONE;
          else
            state_n = S_GAP;
        end
      end
      S_DONE: viol = pend;
      default: state_n = S_GAP;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_GAP;
      req    <= 1'b0;
      data   <= START_V;
      sent   <= '0;
      cnt    <= '0;
      viol_r <= 1'b0;
    end else begin
      state  <= state_n;
      req    <= req_n;
      data   <= data_n;
      sent   <= sent_n;
      cnt    <= cnt_n;
      viol_r <= viol_r | viol;
    end
  end

`ifdef SOURCE2_TIMEOUT_EN
  logic [15:0] wcnt;

  // Cleared outside WAIT so every WAIT entry starts from zero;
  // saturates once the limit is reached.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt <= '0;
      tmo  <= 1'b0;
    end else if (state != S_WAIT) begin
      wcnt <= '0;
    end else if (pend) begin
      if (wcnt == 16'(TIMEOUT - 1))
        tmo <= 1'b1;
      else
        wcnt <= wcnt + 16'd1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  assign done = (state == S_DONE);
  assign err  = {tmo, viol_r};

endmodule

// File: tb/tb_source2.sv
// tb_source2: directed bench for source2 with a cycle model and
// a per-cycle compare process on two instances.
module tb_source2;

`ifdef SOURCE2_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif
  localparam int PER = 4;
  localparam int TOUT = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;
  logic ack0 = 1'b0;
  logic ack1 = 1'b0;
  logic req0, req1, done0, done1;
  logic [7:0] data0, data1;
  logic [15:0] sent0, sent1;
  logic [1:0] err0, err1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fr0 = 0;
  int fd0 = 0;
  bit sink0 = 1'b1;

  source2 #(.ID(0), .SIZE(8), .PERIOD(PER), .COUNT(0),
            .START(0), .STEP(1), .TIMEOUT(TOUT)) u0 (
    .clk(clk), .reset(reset), .en(en), .req(req0),
    .ack(ack0), .data(data0), .sent(sent0),
    .done(done0), .err(err0));

  source2 #(.ID(1), .SIZE(8), .PERIOD(PER), .COUNT(3),
            .START(8'hF0), .STEP(8'h08), .TIMEOUT(TOUT)) u1 (
    .clk(clk), .reset(reset), .en(en), .req(req1),
    .ack(ack1), .data(data1), .sent(sent1),
    .done(done1), .err(err1));

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset)
    if (!reset) cyc <= 0;
    else cyc <= cyc + 1;

  // Consumers: answer a req change one edge later; ack0 can be
  // held off or forced to flip for error scenarios.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
    end else begin
      if (fd0 != fr0) begin
        ack0 <= ~ack0;
        fd0  <= fr0;
      end else if (sink0 && req0 != ack0) begin
        ack0 <= req0;
      end
      if (req1 != ack1) ack1 <= req1;
    end
  end

  typedef struct {
    bit req;
    int data;
    int sent;
    bit e0;
    bit e1;
    bit busy;
    bit fin;
    int gap;
    int wc;
  } mdl_t;

  function automatic mdl_t minit(int st);
    mdl_t m;
    m.req = 0; m.data = st % 256; m.sent = 0;
    m.e0 = 0; m.e1 = 0; m.busy = 0; m.fin = 0;
    m.gap = 0; m.wc = 0;
    return m;
  endfunction

  function automatic mdl_t mstep(mdl_t mi, bit en_i, bit ack_i,
                                 int lim, int st, int sp);
    mdl_t m = mi;
    if (m.fin) begin
      if (ack_i != m.req) m.e0 = 1;
    end else if (m.busy) begin
      if (ack_i == m.req) begin
        m.sent = (m.sent + 1) % 65536;
        m.busy = 0;
        m.gap = 0;
        if (lim != 0 && m.sent == lim) m.fin = 1;
      end else begin
        m.wc++;
        if (TO_ON && m.wc >= TOUT) m.e1 = 1;
      end
    end else begin
      if (ack_i != m.req) m.e0 = 1;
      if (en_i) begin
        m.gap++;
        if (m.gap == PER) begin
          m.req = !m.req;
          m.data = (st + m.sent * sp) % 256;
          m.busy = 1;
          m.wc = 0;
        end
      end
    end
    return m;
  endfunction

  mdl_t m0, m1;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m0 <= minit(0);
      m1 <= minit(240);
    end else begin
      m0 <= mstep(m0, en, ack0, 0, 0, 1);
      m1 <= mstep(m1, en, ack1, 3, 240, 8);
    end
  end

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("u0.req", int'(req0), int'(m0.req));
    chk("u0.data", int'(data0), m0.data);
    chk("u0.sent", int'(sent0), m0.sent);
    chk("u0.done", int'(done0), int'(m0.fin));
    chk("u0.err", int'(err0), int'({m0.e1, m0.e0}));
    chk("u1.req", int'(req1), int'(m1.req));
    chk("u1.data", int'(data1), m1.data);
    chk("u1.sent", int'(sent1), m1.sent);
    chk("u1.done", int'(done1), int'(m1.fin));
    chk("u1.err", int'(err1), int'({m1.e1, m1.e0}));
  end

  task automatic wait_sent0();
    logic [15:0] s = sent0;
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sent0 != s) begin ok = 1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL wait_sent0 got=stuck want=change");
    end
  endtask

  task automatic wait_req0();
    logic r = req0;
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req0 != r) begin ok = 1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL wait_req0 got=stuck want=toggle");
    end
  endtask

  int e;
  int s;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst.req0", int'(req0), 0);
    chk("rst.data1", int'(data1), 'hF0);
    chk("rst.sent0", int'(sent0), 0);
    reset = 1'b1;
    en = 1'b1;
    repeat (4) @(negedge clk);
    chk("t1.req@4", int'(req0), 1);
    chk("t1.data@4", int'(data0), 0);
    repeat (6) @(negedge clk);
    chk("t1.req@10", int'(req0), 0);
    chk("t1.data@10", int'(data0), 1);
    repeat (6) @(negedge clk);
    chk("t1.data@16", int'(data0), 2);
    chk("t2.data3", int'(data1), 'h00);
    repeat (4) @(negedge clk);
    chk("t2.done", int'(done1), 1);
    chk("t2.sent", int'(sent1), 3);
    chk("t2.req", int'(req1), 1);

    wait_sent0();
    e = cyc;
    @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);
    en = 1'b1;
    wait_req0();
    chk("t3.launch", cyc, e + 9);
    en = 1'b0;
    wait_sent0();
    chk("t3.wait_en0", cyc, e + 11);
    en = 1'b1;

    s = int'(sent0);
    sink0 = 1'b0;
    fr0++;
    @(negedge clk);
    fr0++;
    @(negedge clk);
    chk("t4.err0", int'(err0[0]), 1);
    chk("t4.sent", int'(sent0), s);
    sink0 = 1'b1;

    wait_req0();
    sink0 = 1'b0;
    repeat (12) @(negedge clk);
    chk("t5.err1", int'(err0[1]), int'(TO_ON));
    chk("t5.hold", int'(sent0), s);
    sink0 = 1'b1;
    wait_sent0();
    chk("t5.late", int'(sent0), s + 1);
    chk("t5.sticky", int'(err0[1]), int'(TO_ON));

    wait_req0();
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6.req", int'(req0), 0);
    chk("t6.data", int'(data0), 0);
    chk("t6.sent", int'(sent0), 0);
    chk("t6.err", int'(err0), 0);
    chk("t6.done1", int'(done1), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6.restart", int'(req0), 1);
    chk("t6.cyc", cyc, 4);
    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
